vec_mem_seq: RTL
================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 Parameter: LANES, 8, elements per vector.
REQ-002 Parameter: ELEM_W, 24, element width in bits; vector width = LANES*ELEM_W = 192.
REQ-003 Parameter: ADDR_W, 21, data-memory address width.
REQ-004 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: req_valid  in  1  MEM-stage request present.
REQ-007 Port: req_op  in  4  mem control; bit3 = memory-op enable, bits[2:0] opcode: 000 load, 001 store.
REQ-008 Port: req_addr  in  ADDR_W  vector base address.
REQ-009 Port: req_data  in  192  store vector.
REQ-010 Port: stall  out  1  hold upstream pipeline.
REQ-011 Port: resp_valid  out  1  one-cycle completion pulse, load or store.
REQ-012 Port: resp_data  out  192  assembled load vector.
REQ-013 Port: dm_addr  out  ADDR_W; dm_wdata  out  ELEM_W; dm_we  out  1; dm_re  out  1  element port to data memory.
REQ-014 Port: dm_rdata  in  ELEM_W  read data, valid exactly one cycle after dm_re.

Function
REQ-015 FSM states: IDLE, RD, RD_WAIT, WR, DONE.
REQ-016 Accept only in IDLE when req_valid=1, req_op[3]=1 and opcode is 000 or 001; latch addr, data and op type on that edge (cycle T).
REQ-017 Any other req_op (bit3=0, or opcode not 000/001): not accepted, FSM stays IDLE, no dm activity, no stall.
REQ-018 stall=1 in every state except IDLE; stall=0 in the accept cycle T.
REQ-019 Lane i occupies bits [ELEM_W*i+ELEM_W-1 : ELEM_W*i], address base+i modulo 2^ADDR_W (wraps, no error).
REQ-020 Load: RD for T+1..T+8, issuing lane i (dm_re=1) at T+1+i; lane i captured from dm_rdata at T+2+i; RD_WAIT at T+9 captures lane 7; DONE at T+10.
REQ-021 Store: WR for T+1..T+8, dm_we=1, dm_wdata = lane i at T+1+i; DONE at T+9.
REQ-022 DONE: resp_valid=1 for exactly one cycle, then IDLE; next accept no earlier than the following cycle.
REQ-023 resp_data updates only on load completion; holds its value through stores and idle.
REQ-024 dm_we and dm_re never both 1; both 0 outside RD/WR; dm_addr and dm_wdata are don't-care when both are 0.
REQ-025 req_* changes while stall=1 are ignored.

Reset
REQ-026 rst=1 at an edge forces IDLE, lane counter 0, resp_data 0, resp_valid 0, dm_we 0, dm_re 0, stall 0 from the next cycle.
REQ-027 Reset mid-operation aborts without rollback: stored elements remain in memory and the partial load is discarded.

Configuration
REQ-028 Macro VEC_MEM_SEQ_STRIDE_EN defined: add port req_stride  in  ADDR_W, latched at accept; lane i address = base + i*stride modulo 2^ADDR_W.
REQ-029 Macro undefined: no req_stride port; unit stride per REQ-019.

Structure
REQ-030 Package vmem_pkg holds LANES, ELEM_W, ADDR_W, the opcode constants (LOAD=3'b000, STORE=3'b001) and the FSM state enum.
REQ-031 Sub-module vmem_lane_buf: 192-bit element assembly/disassembly buffer indexed by lane counter, one instance.

Verification
REQ-032 Load base 0x00010, memory[0x10+i]=0x100000+i -> dm_re at T+1..T+8, resp_valid at T+10, resp_data lane i = 0x100000+i, stall=1 for T+1..T+10.
REQ-033 Store base 0x1FFFFC, lanes = 0xA0000i -> dm_we at 0x1FFFFC..0x1FFFFF then 0x000000..0x000003 (wrap), resp_valid at T+9.
REQ-034 req_op=4'b0000 and 4'b1010 with req_valid=1 -> no stall, dm_we=dm_re=0, resp_valid=0.
REQ-035 rst at T+4 of a store -> lanes 0..2 written, lane 3 onward not written, IDLE and stall=0 at T+5, resp_valid never asserted.
REQ-036 Back-to-back load then store held valid upstream -> second accept at T+11, no overlap of dm_re/dm_we, resp_valid pulses at T+10 and T+20.
REQ-037 VEC_MEM_SEQ_STRIDE_EN, stride 4, base 0x20 -> load addresses 0x20,0x24,...,0x3C.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared constants, opcodes and FSM states for the vector memory sequencer.
// Stride support is enabled by defining VEC_MEM_SEQ_STRIDE_EN.
package vmem_pkg;

  localparam int LANES  = 8;
  localparam int ELEM_W = 24;
  localparam int ADDR_W = 21;

  localparam logic [2:0] LOAD  = 3'b000;
  localparam logic [2:0] STORE = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/vmem_lane_buf.sv
// Vector assembly/disassembly buffer addressed one element lane at a time.
// vec_nx exposes the buffer with the pending lane write already merged.
module vmem_lane_buf #(
  parameter int LANES  = vmem_pkg::LANES,
  parameter int ELEM_W = vmem_pkg::ELEM_W,
  parameter int CW     = $clog2(vmem_pkg::LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [LANES*ELEM_W-1:0] load_data,
  input  logic                    wr,
  input  logic [CW-1:0]           wr_lane,
  input  logic [ELEM_W-1:0]       wr_elem,
  input  logic [CW-1:0]           rd_lane,
  output logic [ELEM_W-1:0]       rd_elem,
  output logic [LANES*ELEM_W-1:0] vec_nx
);

  logic [LANES*ELEM_W-1:0] vec;

  always_comb begin
    vec_nx = vec;
    if (wr)
      vec_nx[int'(wr_lane)*ELEM_W +: ELEM_W] = wr_elem;
  end

  assign rd_elem = vec[int'(rd_lane)*ELEM_W +: ELEM_W];

  always_ff @(posedge clk) begin
    if (rst)
      vec <= '0;
    else if (load)
      vec <= load_data;
    else
      vec <= vec_nx;
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Sequences a vector load/store into per-element data-memory accesses.
// VEC_MEM_SEQ_STRIDE_EN adds req_stride for strided lane addressing.
module vec_mem_seq #(
  parameter int LANES  = vmem_pkg::LANES,
  parameter int ELEM_W = vmem_pkg::ELEM_W,
  parameter int ADDR_W = vmem_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [3:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES*ELEM_W-1:0] req_data,
`ifdef VEC_MEM_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0]       req_stride,
`endif
  output logic                    stall,
  output logic                    resp_valid,
  output logic [LANES*ELEM_W-1:0] resp_data,
  output logic [ADDR_W-1:0]       dm_addr,
  output logic [ELEM_W-1:0]       dm_wdata,
  output logic                    dm_we,
  output logic                    dm_re,
  input  logic [ELEM_W-1:0]       dm_rdata
);

  import vmem_pkg::*;

  localparam int CW = $clog2(LANES);

  state_t                  state;
  state_t                  state_nx;
  logic [CW-1:0]           cnt;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W-1:0]       step;
  logic                    accept;
  logic                    last;
  logic                    buf_wr;
  logic [CW-1:0]           wr_lane;
  logic [ELEM_W-1:0]       rd_elem;
  logic [LANES*ELEM_W-1:0] vec_nx;

  assign accept = state == IDLE && req_valid && req_op[3]
               && (req_op[2:0] == LOAD || req_op[2:0] == STORE);
  assign last   = cnt == CW'(LANES - 1);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (req_op[2:0] == STORE) ? WR : RD;
      end
      RD:      if (last) state_nx = RD_WAIT;
      RD_WAIT: state_nx = DONE;
      WR:      if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gating with rst keeps an aborting cycle from touching memory.
  assign stall      = state != IDLE;
  assign resp_valid = state == DONE;
  assign dm_re      = state == RD && !rst;
  assign dm_we      = state == WR && !rst;
  assign dm_addr    = addr;
  assign dm_wdata   = rd_elem;

  // Read data trails dm_re by one cycle, so capture lags the issue lane.
  assign buf_wr  = (state == RD && cnt != '0) || state == RD_WAIT;
  assign wr_lane = (state == RD_WAIT) ? CW'(LANES - 1) : cnt - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      addr      <= '0;
      step      <= '0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        addr <= req_addr;
`ifdef VEC_MEM_SEQ_STRIDE_EN
        step <= req_stride;
`else
        step <= ADDR_W'(1);
`endif
      end else if (state == RD || state == WR) begin
        cnt  <= cnt + CW'(1);
        addr <= addr + step;
      end
      if (state == RD_WAIT)
        resp_data <= vec_nx;
    end
  end

  vmem_lane_buf #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .CW     (CW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (req_data),
    .wr        (buf_wr),
    .wr_lane   (wr_lane),
    .wr_elem   (dm_rdata),
    .rd_lane   (cnt),
    .rd_elem   (rd_elem),
    .vec_nx    (vec_nx)
  );

endmodule
